// File: rtl/interval_timer.sv
// interval_timer: prescaled tick counter with one-shot / periodic expiry.
// A prescaler divides clk into ticks of PRESCALE cycles; the tick counter
// runs up to a latched target and emits a one-cycle count_out pulse on expiry.
// Optional feature: define INTERVAL_TIMER_PAUSE_EN to add the pause input.
module interval_timer #(
  parameter int unsigned PRESCALE = 50_000_000,
  parameter int unsigned TICK_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              stop,
  input  logic              periodic,
  input  logic [TICK_W-1:0] ticks,
`ifdef INTERVAL_TIMER_PAUSE_EN
  input  logic              pause,
`endif
  output logic              count_out,
  output logic              busy,
  output logic [TICK_W-1:0] elapsed
);

  localparam int unsigned    PS_W    = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [PS_W-1:0]   prescaler;
  logic [TICK_W-1:0] target;
  logic              mode;
  logic              hold;

  // Freeze request from the optional pause input.
`ifdef INTERVAL_TIMER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // Control FSM, prescaler and tick counter; priority stop > restart > expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prescaler <= '0;
      target    <= '0;
      mode      <= 1'b0;
      elapsed   <= '0;
      busy      <= 1'b0;
      count_out <= 1'b0;
    end else begin
      count_out <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && !stop && (ticks != '0)) begin
            state     <= RUN;
            busy      <= 1'b1;
            target    <= ticks;
            mode      <= periodic;
            prescaler <= '0;
            elapsed   <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (enable && (ticks != '0)) begin
            // A zero target cannot be latched, so a restart with ticks=0 is
            // ignored and the current interval keeps counting.
            target    <= ticks;
            mode      <= periodic;
            prescaler <= '0;
            elapsed   <= '0;
          end else if (!hold) begin
            if (prescaler == PS_LAST) begin
              prescaler <= '0;
              if (elapsed + TICK_W'(1) == target) begin
                count_out <= 1'b1;
                if (mode) begin
                  elapsed <= '0;
                end else begin
                  elapsed <= target;
                  state   <= IDLE;
                  busy    <= 1'b0;
                end
              end else begin
                elapsed <= elapsed + TICK_W'(1);
              end
            end else begin
              prescaler <= prescaler + PS_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
